// File: rtl/zigzag_reorder_buf.sv
// Ping-pong 8x8 coefficient buffer: blocks arrive in raster order (or column-major)
// and leave in JPEG zigzag scan order, with valid/ready back-pressure on both sides.
module zigzag_reorder_buf #(
  parameter int DWIDTH     = 12,
  parameter bit TRANSPOSE  = 1'b0,
  parameter bit SOF_RESYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              sof_err
);

  // Raster index of each zigzag scan position.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DWIDTH-1:0] mem [2][64];
  logic              wr_bank, rd_bank;
  logic [5:0]        wr_cnt, rd_cnt;
  logic [1:0]        full;

  logic       wr_accept, resync, wr_done, rd_xfer, rd_done;
  logic [5:0] wr_idx, zz_raw, rd_addr;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // valid never depends on ready, and ready/valid derive only from registered full bits.
  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];

  assign wr_accept = in_valid & in_ready;
  assign resync    = SOF_RESYNC & in_sof & (wr_cnt != 6'd0);
  assign wr_idx    = resync ? 6'd0 : wr_cnt;
  assign wr_done   = wr_accept & ~resync & (wr_cnt == 6'd63);
  assign rd_xfer   = out_valid & out_ready;
  assign rd_done   = rd_xfer & (rd_cnt == 6'd63);

  // Column-major input swaps row and column bits of the raster index.
  assign zz_raw  = ZZ[rd_cnt];
  assign rd_addr = TRANSPOSE ? {zz_raw[2:0], zz_raw[5:3]} : zz_raw;

  assign out_data = out_valid ? mem[rd_bank][rd_addr] : '0;
  assign out_last = out_valid & (rd_cnt == 6'd63);

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_bank][wr_idx] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      rd_cnt  <= 6'd0;
      full    <= 2'b00;
      sof_err <= 1'b0;
    end else begin
      sof_err <= wr_accept & resync;
      if (wr_accept) begin
        if (resync) begin
          wr_cnt <= 6'd1;
        end else begin
          wr_cnt <= wr_cnt + 6'd1;
          if (wr_cnt == 6'd63) wr_bank <= ~wr_bank;
        end
      end
      if (rd_xfer) begin
        rd_cnt <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63) rd_bank <= ~rd_bank;
      end
      // Write and read never complete on the same bank in one cycle.
      if (wr_done && !wr_bank)      full[0] <= 1'b1;
      else if (rd_done && !rd_bank) full[0] <= 1'b0;
      if (wr_done && wr_bank)       full[1] <= 1'b1;
      else if (rd_done && rd_bank)  full[1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zigzag_reorder_buf.sv
// Directed bench for zigzag_reorder_buf: a linear stimulus sequence plus a negedge
// scoreboard that checks every output transfer against an expected queue.
module tb_zigzag_reorder_buf;

  localparam int W = 12;

  int zz [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_sof = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_last, sof_err, out_ready;
  logic [W-1:0] out_data;

  logic         t_in_valid = 1'b0, t_in_sof = 1'b0;
  logic [W-1:0] t_in_data = '0;
  logic         t_in_ready, t_out_valid, t_out_last, t_sof_err;
  logic [W-1:0] t_out_data;

  int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic rnd_bit  = 1'b0;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = (rdy_mode == 1) || (rdy_mode == 2 && rnd_bit);

  zigzag_reorder_buf #(.DWIDTH(W), .TRANSPOSE(1'b0), .SOF_RESYNC(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sof_err(sof_err)
  );

  zigzag_reorder_buf #(.DWIDTH(W), .TRANSPOSE(1'b1), .SOF_RESYNC(1'b1)) dut_t (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_sof(t_in_sof), .in_data(t_in_data),
    .out_valid(t_out_valid), .out_ready(1'b1), .out_data(t_out_data),
    .out_last(t_out_last), .sof_err(t_sof_err)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int stall_cycles = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer pops the queue; stalled beats must hold still.
  int           mon_cnt = 0;
  logic         stall_prev = 1'b0, prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      mon_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        chk("out_last", 32'(out_last), 32'(mon_cnt == 63));
        mon_cnt = (mon_cnt + 1) % 64;
      end else if (!out_valid) begin
        chk("idle_data", 32'(out_data), 32'd0);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic put(input logic [W-1:0] d, input logic sof);
    logic acc;
    int   t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof;
    forever begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      stall_cycles++;
      t++;
      if (t > 3000) begin
        chk("put_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic push_block(input logic [W-1:0] d [64]);
    for (int k = 0; k < 64; k++) exp_q.push_back(d[zz[k]]);
  endtask

  task automatic send_block(input int base, input bit gaps);
    logic [W-1:0] d [64];
    for (int i = 0; i < 64; i++) d[i] = W'(base + i);
    push_block(d);
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      put(d[i], i == 0);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] d [64];
    int t;

    // Reset values
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single block, raster data, latency and order
    rdy_mode = 1;
    for (int i = 0; i < 64; i++) d[i] = W'(i);
    push_block(d);
    for (int i = 0; i < 64; i++) begin
      put(d[i], i == 0);
      if (i == 62) chk("lat_before", 32'(out_valid), 32'd0);
      if (i == 63) chk("lat_first", 32'(out_valid), 32'd1);
      if (i == 63) chk("first_beat", 32'(out_data), 32'd0);
    end
    wait_drain();

    // 2: three back-to-back blocks, no input stall
    stall_cycles = 0;
    for (int b = 0; b < 3; b++) send_block(64 * b, 1'b0);
    chk("b2b_stalls", 32'(stall_cycles), 32'd0);
    chk("b2b_sof_err", 32'(sof_err), 32'd0);
    wait_drain();

    // 3: consumer stalled, exactly two blocks fit
    rdy_mode = 0;
    stall_cycles = 0;
    send_block(12'h400, 1'b0);
    send_block(12'h500, 1'b0);
    chk("fill_stalls", 32'(stall_cycles), 32'd0);
    in_valid = 1'b1; in_data = 12'h7ff;
    repeat (3) begin
      @(negedge clk);
      chk("both_full_ready", 32'(in_ready), 32'd0);
      chk("both_full_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_mode = 1;
    t = 0;
    while (exp_q.size() > 64 && t < 500) begin
      @(negedge clk); #1;
      chk("drain_ready_low", 32'(in_ready), 32'd0);
      t++;
    end
    @(posedge clk); #1;
    chk("ready_after_read", 32'(in_ready), 32'd1);
    wait_drain();

    // 4: random gaps on both sides, random data
    rdy_mode = 2;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 64; i++) d[i] = W'($urandom_range(0, 4095));
      push_block(d);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        put(d[i], i == 0);
      end
    end
    wait_drain();

    // 5: resync at wr_cnt == 20
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) put(W'(12'hA00 + i), i == 0);
    chk("pre_sof_err", 32'(sof_err), 32'd0);
    d[0] = 12'h555;
    for (int i = 1; i < 64; i++) d[i] = W'(12'hB00 + i);
    push_block(d);
    put(d[0], 1'b1);
    chk("sof_err_pulse", 32'(sof_err), 32'd1);
    put(d[1], 1'b0);
    chk("sof_err_once", 32'(sof_err), 32'd0);
    for (int i = 2; i < 64; i++) put(d[i], 1'b0);
    wait_drain();

    // 6: reset mid-output at rd_cnt == 30 with both banks full
    rdy_mode = 0;
    send_block(12'h100, 1'b0);
    send_block(12'h200, 1'b0);
    rdy_mode = 1;
    t = 0;
    while (exp_q.size() > 98 && t < 500) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1;
    rdy_mode = 0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    send_block(12'h300, 1'b1);
    wait_drain();

    // Column-major build: transposed input yields the plain zigzag index sequence
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        t_in_valid = 1'b1; t_in_sof = (i == 0 && j == 0);
        t_in_data  = W'(j * 8 + i);
        @(negedge clk);
        chk("t_in_ready", 32'(t_in_ready), 32'd1);
        @(posedge clk); #1;
      end
    end
    t_in_valid = 1'b0; t_in_sof = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("t_valid", 32'(t_out_valid), 32'd1);
      chk("t_data", 32'(t_out_data), 32'(zz[k]));
      chk("t_last", 32'(t_out_last), 32'(k == 63));
      @(posedge clk); #1;
    end
    chk("t_empty", 32'(t_out_valid), 32'd0);
    chk("t_sof_err", 32'(t_sof_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zigzag_reorder_buf.md
Name: zigzag_reorder_buf

Overview:
- Parametrised successor to the fixed zigzag result register bank of the jpeg_encoder fdct_zigzag path.
- Accepts 8x8 blocks of DCT coefficients, one per beat, in raster order (optionally column-major) and emits them in JPEG zigzag scan order.
- Sits between fdct and the quantiser.
- Ping-pong double buffering lets the next block's input overlap the current block's output. Valid/ready handshakes on both sides give full back-pressure support.

Parameters:
- DWIDTH, 12, coefficient width in bits.
- TRANSPOSE, 0, 1 means input arrives column-major; the scan table uses transposed indices.
- SOF_RESYNC, 1, 1 means in_sof on a mid-block beat discards the partial block and restarts at index 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  buffer can accept a beat.
- in_sof  in  1  first coefficient of a block.
- in_data  in  DWIDTH  coefficient.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DWIDTH  coefficient in zigzag order.
- out_last  out  1  high on zigzag index 63.
- sof_err  out  1  one-cycle pulse on a resync event.

Behaviour:
- Storage: 2 banks x 64 x DWIDTH flops. State: wr_bank, rd_bank (1b each); wr_cnt, rd_cnt (6b each); full[1:0].
- Reset (async, rst=1), with all values in effect immediately:
  - wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=00.
  - in_ready=1, out_valid=0, out_last=0, sof_err=0, out_data=0.
  - Storage contents are don't-care.
- Write side:
  - in_ready = !full[wr_bank].
  - Accept = in_valid & in_ready. On accept, mem[wr_bank][wr_cnt] <= in_data and wr_cnt++.
  - On accepting wr_cnt==63: wr_cnt wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Resync (SOF_RESYNC=1):
  - An accept with in_sof=1 and wr_cnt!=0 writes in_data to index 0 and sets wr_cnt=1.
  - The partial block is discarded and sof_err pulses for 1 cycle.
  - in_sof with wr_cnt==0 is normal.
  - in_sof=0 at wr_cnt==0 is accepted silently.
  - With SOF_RESYNC=0, in_sof is ignored.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = mem[rd_bank][ZZ(rd_cnt)] while out_valid; otherwise 0.
  - out_last = out_valid & (rd_cnt==63).
  - On out_valid & out_ready, rd_cnt++. On the index-63 transfer: rd_cnt wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- ZZ table (raster index by zigzag position): 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
  - With TRANSPOSE=1, each entry r maps to (r%8)*8 + r/8.
- Latency: out_valid rises the cycle after the accept of input index 63, with the first output beat = raster index 0.
- Throughput: 1 beat/cycle sustained on both sides when out_ready=1.
- Simultaneous events: a write completing on one bank and a read completing on the other bank in the same cycle both update full; the two bits are independent.
  - A bank is never written while full; full gates in_ready.
  - A bank is never read while empty.
- Both banks full: in_ready=0 until the read of index 63 completes. in_ready rises the following cycle.
- Stalling: out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Reset mid-block: all blocks in flight are discarded; the first beat after reset release is treated as index 0.

Test Plan:
1. Single block, in_data = raster index 0..63, out_ready=1 -> out_data sequence 0,1,8,16,9,2,3,10,...,62,63. out_last only on the 64th beat. out_valid first asserts 1 cycle after the 64th accept.
2. Three back-to-back blocks (block b data = 64b+i), out_ready=1 -> in_ready never drops. Outputs follow the ZZ order offset by 64b. Bank toggles are visible.
3. out_ready=0 throughout with continuous input -> exactly 128 beats accepted, then in_ready=0. After out_ready=1 and 64 reads, in_ready=1 on the next cycle.
4. Random out_ready (50%) and random in_valid over 10 blocks -> scoreboard matches the ZZ permutation and out_data is stable under stall.
5. in_sof asserted at wr_cnt=20 -> sof_err pulses 1 cycle. The next emitted block starts with the in_data of the sof beat, and the 20 earlier beats never appear.
6. rst pulsed mid-output at rd_cnt=30 with bank 1 full -> out_valid=0 and in_ready=1 immediately. After release, a fresh block comes out in correct order. TRANSPOSE=1 build: input i*8+j = value j*8+i gives the output sequence 0,1,8,16,...
